// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder and its boot loader.
// Loader state encoding, memory-mapped port addresses and the stored word width.
package mem_pkg;
   typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} ld_state_t;
   localparam logic [7:0] ADDR_OUT    = 8'hFF;
   localparam logic [7:0] ADDR_STATUS = 8'hFE;
   localparam int         WORD_W      = 15;
endpackage

// File: rtl/mem_loader.sv
// mem_loader: byte-stream boot loader that packs byte pairs into words and holds the processor in reset.
// Ports: clk, reset_n (async, active-low); ld_valid/ld_byte/ld_done in, ld_ready out (byte stream);
//        cpu_hold out (processor reset); we/addr/data out (write port into the word array).
module mem_loader
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int LOAD_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_done,
   output logic              ld_ready,
   output logic              cpu_hold,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [WORD_W-1:0] data
);
   ld_state_t         state, state_nx;
   logic [6:0]        hi_reg;
   logic [ADDR_W-1:0] ld_addr;
   logic              last;
   assign last = ld_addr == ADDR_W'(LOAD_WORDS - 1);
   always_comb begin
      state_nx = state;
      ld_ready = 1'b0;
      case (state)
         LOAD_HI: begin
            ld_ready = ~ld_done;
            state_nx = ld_done ? RUN : ld_valid ? LOAD_LO : LOAD_HI;
         end
         LOAD_LO: begin
            ld_ready = 1'b1;
            state_nx = ~ld_valid ? LOAD_LO : last ? RUN : LOAD_HI;
         end
         default: state_nx = RUN;
      endcase
   end
   // cpu_hold tracks the next state so it drops on the very edge that enters RUN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= LOAD_HI;
         hi_reg   <= '0;
         ld_addr  <= '0;
         cpu_hold <= 1'b1;
      end else begin
         state    <= state_nx;
         cpu_hold <= state_nx != RUN;
         if (state == LOAD_HI && ld_valid && !ld_done) hi_reg <= ld_byte[6:0];
         if (state == LOAD_LO && ld_valid && !last) ld_addr <= ld_addr + ADDR_W'(1);
      end
   assign we   = state == LOAD_LO && ld_valid;
   assign addr = ld_addr;
   assign data = {hi_reg, ld_byte};
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word store, boot loader and memory-mapped output port behind the processor bus.
// Ports: clk, reset_n (async, active-low); Adr/MemWrite/WriteData in, ReadData out (processor bus);
//        cpu_hold out; ld_valid/ld_byte/ld_done in, ld_ready out (loader); out_data/out_valid out, out_ready in.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = 8,
   parameter int LOAD_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] Adr,
   input  logic              MemWrite,
   input  logic [7:0]        WriteData,
   output logic [WORD_W-1:0] ReadData,
   output logic              cpu_hold,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_done,
   output logic              ld_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   logic [WORD_W-1:0] mem [DEPTH];
   logic              ld_we;
   logic [ADDR_W-1:0] ld_waddr;
   logic [WORD_W-1:0] ld_wdata;
   logic              overflow, cpu_wr, is_out, is_status, out_acc;
   mem_loader #(.ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS)) u_loader (
      .clk      (clk),
      .reset_n  (reset_n),
      .ld_valid (ld_valid),
      .ld_byte  (ld_byte),
      .ld_done  (ld_done),
      .ld_ready (ld_ready),
      .cpu_hold (cpu_hold),
      .we       (ld_we),
      .addr     (ld_waddr),
      .data     (ld_wdata)
   );
   assign cpu_wr    = MemWrite & ~cpu_hold;
   assign is_out    = Adr == ADDR_W'(ADDR_OUT);
   assign is_status = Adr == ADDR_W'(ADDR_STATUS);
   // a write is accepted when the port is empty or being drained this same cycle
   assign out_acc   = cpu_wr & is_out & (~out_valid | out_ready);
   // loader and processor writes never overlap: the loader only writes while cpu_hold is high
   always_ff @(posedge clk)
      if (ld_we) mem[ld_waddr] <= ld_wdata;
      else if (cpu_wr && Adr < ADDR_W'(ADDR_STATUS)) mem[Adr] <= {{(WORD_W-8){1'b0}}, WriteData};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (out_acc) begin
            out_valid <= 1'b1;
            out_data  <= WriteData;
         end else if (out_valid && out_ready) out_valid <= 1'b0;
         if (cpu_wr && is_out && !out_acc) overflow <= 1'b1;
         else if (cpu_wr && is_status) overflow <= 1'b0;
      end
   assign ReadData = is_out    ? {{(WORD_W-8){1'b0}}, out_data} :
                     is_status ? {{(WORD_W-2){1'b0}}, overflow, out_valid} :
                                 mem[Adr];
endmodule
